// File: rtl/seq_event_monitor_if.sv
// Record port of seq_event_monitor: valid/ready handshake carrying (count, gap).
// The monitor drives it through the master modport; the host/logger uses slave.
interface seq_event_monitor_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 16
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_count;
  logic [GAP_W-1:0] evt_gap;

  modport master (
    output evt_valid,
    output evt_count,
    output evt_gap,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    input  evt_gap,
    output evt_ready
  );
endinterface

// File: rtl/seq_event_monitor.sv
// Counts seq_detected pulses, measures inter-detection gaps and presents each as a record.
// Optional detection timeout is compiled in when SEQ_MON_TIMEOUT_EN is defined.
module seq_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 16,
  parameter int MAX_GAP = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic seq_detected,
  input  logic clr,
  seq_event_monitor_if.master evt,
  output logic ovf,
  output logic timeout
);

  // MAX_GAP must stay below the saturation value or the compare could never fire.
  if (MAX_GAP >= (2 ** GAP_W) - 1) begin : g_bad_max_gap
    $error("seq_event_monitor: MAX_GAP must be < 2^GAP_W - 1");
  end

`ifdef SEQ_MON_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TIMEOUT} state_e;
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);
`else
  typedef enum logic [0:0] {S_IDLE, S_ARMED} state_e;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [GAP_W-1:0] rec_gap_q, rec_gap_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap_now;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      rec_cnt_q <= '0;
      rec_gap_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rec_cnt_q <= rec_cnt_d;
      rec_gap_q <= rec_gap_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    rec_cnt_d = rec_cnt_q;
    rec_gap_d = rec_gap_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;

    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // The first detection after reset/clr has no predecessor, so its gap is 0.
    gap_now = (state_q == S_IDLE) ? '0 : gap_q;

    if (valid_q && evt.evt_ready) begin
      valid_d = 1'b0;
    end

    if (seq_detected) begin
      cnt_d   = cnt_inc;
      gap_d   = GAP_W'(1);
      state_d = S_ARMED;
      // Oldest record wins: a detection that finds the holder busy is dropped.
      if (!valid_q || evt.evt_ready) begin
        valid_d   = 1'b1;
        rec_cnt_d = cnt_inc;
        rec_gap_d = gap_now;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (state_q != S_IDLE) begin
      if (gap_q != GAP_MAX) begin
        gap_d = gap_q + 1'b1;
      end
`ifdef SEQ_MON_TIMEOUT_EN
      if (state_q == S_ARMED && gap_q == GAP_LIMIT) begin
        state_d = S_TIMEOUT;
      end
`endif
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_count = rec_cnt_q;
  assign evt.evt_gap   = rec_gap_q;
  assign ovf           = ovf_q;

`ifdef SEQ_MON_TIMEOUT_EN
  assign timeout = (state_q == S_TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_event_monitor.sv
// Directed bench for seq_event_monitor: default instance (MAX_GAP=20) plus a CNT_W=2
// instance for count saturation. Timeout expectations follow SEQ_MON_TIMEOUT_EN.
module tb_seq_event_monitor;

  logic clk;
  logic rst_n;
  logic clr;
  logic seq;
  logic ovf;
  logic timeout;
  logic seq2;
  logic clr2;
  logic ovf2;
  logic timeout2;

  int vectors;
  int miscompares;

  seq_event_monitor_if #(.CNT_W(8), .GAP_W(16)) evt_if ();
  seq_event_monitor_if #(.CNT_W(2), .GAP_W(16)) evt2_if ();

  seq_event_monitor #(.CNT_W(8), .GAP_W(16), .MAX_GAP(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seq_detected (seq),
    .clr          (clr),
    .evt          (evt_if.master),
    .ovf          (ovf),
    .timeout      (timeout)
  );

  seq_event_monitor #(.CNT_W(2), .GAP_W(16), .MAX_GAP(20)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .seq_detected (seq2),
    .clr          (clr2),
    .evt          (evt2_if.master),
    .ovf          (ovf2),
    .timeout      (timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic d, input logic r);
    seq = d;
    evt_if.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] c, input logic [31:0] g);
    chk({tag, ".valid"}, 32'(evt_if.evt_valid), 32'd1);
    chk({tag, ".count"}, 32'(evt_if.evt_count), c);
    chk({tag, ".gap"}, 32'(evt_if.evt_gap), g);
  endtask

  initial begin
    logic [31:0] exp_cnt2 [5];
    logic [31:0] exp_gap2 [5];
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    clr2 = 1'b0;
    seq = 1'b0;
    seq2 = 1'b0;
    evt_if.evt_ready = 1'b0;
    evt2_if.evt_ready = 1'b1;

    // Reset state
    tick(0, 0);
    tick(0, 0);
    chk("rst.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst.count", 32'(evt_if.evt_count), 32'd0);
    chk("rst.gap", 32'(evt_if.evt_gap), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick(0, 1);
    tick(0, 1);

    // Detections spaced 4, 4, 1 with ready held high
    tick(1, 1);
    chk_rec("t1.r1", 1, 0);
    tick(0, 1);
    chk("t1.drain", 32'(evt_if.evt_valid), 32'd0);
    tick(0, 1);
    tick(0, 1);
    tick(1, 1);
    chk_rec("t1.r2", 2, 4);
    tick(0, 1);
    tick(0, 1);
    tick(0, 1);
    tick(1, 1);
    chk_rec("t1.r3", 3, 4);
    tick(1, 1);
    chk_rec("t1.r4", 4, 1);
    chk("t1.ovf", 32'(ovf), 32'd0);
    tick(0, 1);
    chk("t1.idle", 32'(evt_if.evt_valid), 32'd0);

    // Overflow: ready low, detections two edges apart
    clr = 1'b1;
    tick(0, 0);
    clr = 1'b0;
    chk("t2.clr.count", 32'(evt_if.evt_count), 32'd0);
    tick(1, 0);
    chk_rec("t2.r1", 1, 0);
    chk("t2.ovf0", 32'(ovf), 32'd0);
    tick(0, 0);
    tick(1, 0);
    chk_rec("t2.hold", 1, 0);
    chk("t2.ovf1", 32'(ovf), 32'd1);
    tick(0, 0);
    tick(0, 0);
    chk_rec("t2.stable", 1, 0);
    tick(0, 1);
    chk("t2.accept", 32'(evt_if.evt_valid), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0);
    tick(1, 0);
    chk_rec("t2.r3", 3, 8);
    chk("t2.ovf.sticky", 32'(ovf), 32'd1);

    // clr with pending record and ovf; a detection on the same edge is ignored
    clr = 1'b1;
    tick(1, 0);
    clr = 1'b0;
    chk("t6.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("t6.count", 32'(evt_if.evt_count), 32'd0);
    chk("t6.gap", 32'(evt_if.evt_gap), 32'd0);
    chk("t6.ovf", 32'(ovf), 32'd0);
    tick(1, 0);
    chk_rec("t6.r1", 1, 0);

    // Pending record replaced by a detection on the accepting edge
    tick(0, 0);
    tick(1, 1);
    chk_rec("t3.r2", 2, 2);
    chk("t3.ovf", 32'(ovf), 32'd0);

    // Reset while a record is pending
    rst_n = 1'b0;
    tick(0, 0);
    rst_n = 1'b1;
    chk("rstmid.valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rstmid.count", 32'(evt_if.evt_count), 32'd0);

    // Timeout: MAX_GAP=20
    tick(1, 1);
    chk_rec("t5.r1", 1, 0);
    for (int i = 0; i < 19; i++) tick(0, 1);
    chk("t5.before", 32'(timeout), 32'd0);
    tick(0, 1);
`ifdef SEQ_MON_TIMEOUT_EN
    chk("t5.rise", 32'(timeout), 32'd1);
`else
    chk("t5.tied", 32'(timeout), 32'd0);
`endif
    for (int i = 0; i < 9; i++) tick(0, 1);
    tick(1, 1);
    chk("t5.clear", 32'(timeout), 32'd0);
    chk_rec("t5.r2", 2, 30);

    // CNT_W=2 saturation, back-to-back detections
    exp_cnt2 = '{1, 2, 3, 3, 3};
    exp_gap2 = '{0, 1, 1, 1, 1};
    seq = 1'b0;
    seq2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4.count%0d", i), 32'(evt2_if.evt_count), exp_cnt2[i]);
      chk($sformatf("t4.gap%0d", i), 32'(evt2_if.evt_gap), exp_gap2[i]);
    end
    seq2 = 1'b0;
    chk("t4.ovf", 32'(ovf2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
